// File: rtl/halt_ctrl_pkg.sv
// Shared encodings for the debug halt controller: FSM states, halt request
// codes and the stall-vector bit positions for PC, IF, ID, EX, MEM and WB.
package halt_ctrl_pkg;

  typedef enum logic [2:0] {
    HC_RUN        = 3'd0,
    HC_DRAIN      = 3'd1,
    HC_FREEZE     = 3'd2,
    HC_HALTED     = 3'd3,
    HC_STEP       = 3'd4,
    HC_STEP_DRAIN = 3'd5
  } hc_state_e;

  typedef enum logic [1:0] {
    HaltRun  = 2'b00,
    HaltSoft = 2'b01,
    HaltStep = 2'b10,
    HaltHard = 2'b11
  } halt_req_e;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

endpackage

// File: rtl/halt_ctrl_timer.sv
// Loadable down-counter bounding how long the pipeline may take to drain;
// tc_o fires while enabled once the count has run down to zero.
module halt_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/halt_ctrl.sv
// Debug halt controller: turns halt/freeze/single-step requests into the final
// per-stage stall vector, merged with the pipeline's own hazard stalls.
module halt_ctrl
  import halt_ctrl_pkg::*;
#(
  parameter int STALL_W       = 6,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_W         = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         halt_req,
  input  logic [STALL_W-1:0] stall_req_i,
  input  logic [4:0]         pipe_valid,
  input  logic               mem_busy,
  output logic [STALL_W-1:0] stall_o,
  output logic               halted,
  output logic               halt_ack,
  output logic               step_done,
  output logic               drain_timeout,
  output logic [CNT_W-1:0]   halt_cycles
);

  localparam int TMR_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

  hc_state_e        state_q, state_d;
  halt_req_e        req_q, prev_q;
  logic             halted_q;
  logic             step_done_q, step_done_d;
  logic             drain_timeout_q, drain_timeout_d;
  logic [CNT_W-1:0] halt_cycles_q;
  logic             drain_idle, in_drain, tmr_tc;
  logic             unused_pv0;

  // The IF valid bit is not part of the drain condition: IF is already stalled.
  assign unused_pv0 = pipe_valid[0];
  assign drain_idle = (pipe_valid[4:1] == 4'b0000) && !mem_busy;
  assign in_drain   = (state_q == HC_DRAIN) || (state_q == HC_STEP_DRAIN);

  halt_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (!in_drain),
    .en_i       (in_drain),
    .load_val_i (TMR_W'(DRAIN_TIMEOUT - 1)),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d         = state_q;
    stall_o         = stall_req_i;
    step_done_d     = 1'b0;
    drain_timeout_d = 1'b0;
    case (state_q)
      HC_RUN: begin
        if ((req_q == HaltSoft) || (req_q == HaltStep)) begin
          state_d = HC_DRAIN;
        end else if (req_q == HaltHard) begin
          state_d = HC_FREEZE;
        end
      end
      HC_DRAIN: begin
        stall_o[STALL_PC] = 1'b1;
        stall_o[STALL_IF] = 1'b1;
        if (req_q == HaltRun) begin
          state_d = HC_RUN;
        end else if (req_q == HaltHard) begin
          state_d = HC_FREEZE;
        end else if (drain_idle) begin
          state_d = HC_HALTED;
        end else if (tmr_tc) begin
          state_d         = HC_FREEZE;
          drain_timeout_d = 1'b1;
        end
      end
      HC_FREEZE: begin
        // MEM and WB keep their hazard stalls so an in-flight access completes.
        stall_o[STALL_PC] = 1'b1;
        stall_o[STALL_IF] = 1'b1;
        stall_o[STALL_ID] = 1'b1;
        stall_o[STALL_EX] = 1'b1;
        if (req_q == HaltRun) begin
          state_d = HC_RUN;
        end else if (!mem_busy) begin
          state_d = HC_HALTED;
        end
      end
      HC_HALTED: begin
        stall_o = '1;
        if (req_q == HaltRun) begin
          state_d = HC_RUN;
        end else if ((req_q == HaltStep) && (prev_q != HaltStep)) begin
          state_d = HC_STEP;
        end
      end
      HC_STEP: begin
        if (!stall_req_i[STALL_PC]) begin
          state_d = HC_STEP_DRAIN;
        end
      end
      HC_STEP_DRAIN: begin
        stall_o[STALL_PC] = 1'b1;
        stall_o[STALL_IF] = 1'b1;
        if (drain_idle) begin
          state_d     = HC_HALTED;
          step_done_d = 1'b1;
        end else if (tmr_tc) begin
          state_d         = HC_FREEZE;
          drain_timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = HC_RUN;
      end
    endcase
  end

  // Status is registered from the next state so halted drops on the resume edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= HC_RUN;
      req_q           <= HaltRun;
      prev_q          <= HaltRun;
      halted_q        <= 1'b0;
      step_done_q     <= 1'b0;
      drain_timeout_q <= 1'b0;
      halt_cycles_q   <= '0;
    end else begin
      state_q         <= state_d;
      req_q           <= halt_req_e'(halt_req);
      prev_q          <= req_q;
      halted_q        <= (state_d == HC_HALTED);
      step_done_q     <= step_done_d;
      drain_timeout_q <= drain_timeout_d;
      if ((state_q == HC_HALTED) && (halt_cycles_q != '1)) begin
        halt_cycles_q <= halt_cycles_q + 1'b1;
      end
    end
  end

  assign halted        = halted_q;
  assign halt_ack      = halted_q;
  assign step_done     = step_done_q;
  assign drain_timeout = drain_timeout_q;
  assign halt_cycles   = halt_cycles_q;

endmodule
